// File: rtl/dct_seq_pkg.sv
// Shared types and constants for the DCT MAC sequencer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dct_seq_pkg;

  localparam int N_PTS       = 8;  // samples per vector, coefficients per vector
  localparam int IDX_W       = 3;  // width of u and k
  localparam int MAC_LAT_MAX = 3;  // deepest MAC pipeline the drain counter covers

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    EMIT  = 2'd3
  } state_t;

endpackage

// File: rtl/dct_mac_sequencer_if.sv
// Bundles the sequencer's input stream, MAC control bus and output stream.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready and out_valid/out_ready handshakes.
// Ports (master = sequencer side):
//   in_valid/in_ready/in_data        vector input stream
//   mac_sample/mac_coef_row/col      MAC operands, mac_acc_en/mac_clr control
//   mac_result                       accumulator value back from the MAC
//   result_en                        one-cycle capture strobe for the result reg
//   out_valid/out_ready/out_data/out_idx/out_last  coefficient stream
//   busy                             sequencer not idle
interface dct_mac_sequencer_if
  import dct_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 25,
  parameter int N      = 8
);

  logic                     in_valid;
  logic                     in_ready;
  logic [N*DATA_W-1:0]      in_data;
  logic signed [DATA_W-1:0] mac_sample;
  logic [IDX_W-1:0]         mac_coef_row;
  logic [IDX_W-1:0]         mac_coef_col;
  logic                     mac_acc_en;
  logic                     mac_clr;
  logic signed [ACC_W-1:0]  mac_result;
  logic                     result_en;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_data;
  logic [IDX_W-1:0]         out_idx;
  logic                     out_last;
  logic                     busy;

  modport master (
    input  in_valid, in_data, mac_result, out_ready,
    output in_ready, mac_sample, mac_coef_row, mac_coef_col, mac_acc_en,
           mac_clr, result_en, out_valid, out_data, out_idx, out_last, busy
  );

  modport slave (
    output in_valid, in_data, mac_result, out_ready,
    input  in_ready, mac_sample, mac_coef_row, mac_coef_col, mac_acc_en,
           mac_clr, result_en, out_valid, out_data, out_idx, out_last, busy
  );

endinterface

// File: rtl/dct_sample_buf.sv
// N x DATA_W sample register file: parallel load, single indexed read.
// Latency: load visible the cycle after the strobe; read is combinational.
// Backpressure: none; caller strobes load only when it owns the buffer.
// Ports: clk, rst (async, active-high), load, load_data (sample k at
//        [k*DATA_W +: DATA_W]), rd_idx, rd_data.
module dct_sample_buf
  import dct_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [N*DATA_W-1:0]      load_data,
  input  logic [IDX_W-1:0]         rd_idx,
  output logic signed [DATA_W-1:0] rd_data
);

  logic signed [DATA_W-1:0] mem [N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < N; i++) mem[i] <= load_data[i*DATA_W +: DATA_W];
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/dct_mac_sequencer.sv
// Sequences one 8-sample vector through the shared MAC: 8 MAC cycles per
// coefficient u, a MAC_LAT+1 cycle drain, then one registered output beat.
// Latency: first coefficient valid 10+MAC_LAT cycles after input handshake.
// Backpressure: stalls only in EMIT (no MAC activity); in_ready only in IDLE.
// Ports: clk, rst (async, active-high), bus (dct_mac_sequencer_if.master).
module dct_mac_sequencer
  import dct_seq_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 25,
  parameter int N       = 8,
  parameter int MAC_LAT = 1   // 0..MAC_LAT_MAX
) (
  input  logic clk,
  input  logic rst,
  dct_mac_sequencer_if.master bus
);

  localparam int                DRN_W      = $clog2(MAC_LAT_MAX + 1);
  localparam logic [DRN_W-1:0]  DRAIN_INIT = DRN_W'(MAC_LAT);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(N_PTS - 1);

  state_t                   state, state_nxt;
  logic [IDX_W-1:0]         u, u_nxt;
  logic [IDX_W-1:0]         k, k_nxt;
  logic [DRN_W-1:0]         drain_cnt, drain_nxt;
  logic                     buf_load;
  logic                     out_load;
  logic                     out_drop;
  logic signed [DATA_W-1:0] buf_rd;

  logic                     out_valid_q;
  logic signed [ACC_W-1:0]  out_data_q;
  logic [IDX_W-1:0]         out_idx_q;
  logic                     out_last_q;

  dct_sample_buf #(
    .DATA_W (DATA_W),
    .N      (N)
  ) u_sample_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .load_data (bus.in_data),
    .rd_idx    (k),
    .rd_data   (buf_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      u         <= '0;
      k         <= '0;
      drain_cnt <= '0;
    end else begin
      u         <= u_nxt;
      k         <= k_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    u_nxt          = u;
    k_nxt          = k;
    drain_nxt      = drain_cnt;
    buf_load       = 1'b0;
    out_load       = 1'b0;
    out_drop       = 1'b0;
    bus.in_ready   = 1'b0;
    bus.busy       = 1'b1;
    bus.mac_acc_en = 1'b0;
    bus.mac_clr    = 1'b0;
    bus.result_en  = 1'b0;

    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        if (bus.in_valid) begin
          buf_load  = 1'b1;
          u_nxt     = '0;
          k_nxt     = '0;
          state_nxt = MAC;
        end
      end

      MAC: begin
        bus.mac_acc_en = 1'b1;
        // First product of each coefficient reloads the accumulator, so
        // nothing carries over between coefficients or vectors.
        bus.mac_clr    = (k == '0);
        if (k == LAST_IDX) begin
          // k stays at 7 so the mac_* buses hold through DRAIN/EMIT.
          drain_nxt = DRAIN_INIT;
          state_nxt = DRAIN;
        end else begin
          k_nxt = k + IDX_W'(1);
        end
      end

      DRAIN: begin
        if (drain_cnt == '0) begin
          bus.result_en = 1'b1;
          out_load      = 1'b1;
          state_nxt     = EMIT;
        end else begin
          drain_nxt = drain_cnt - DRN_W'(1);
        end
      end

      EMIT: begin
        // out_valid is registered high for the whole of EMIT.
        if (bus.out_ready) begin
          out_drop = 1'b1;
          if (u == LAST_IDX) begin
            state_nxt = IDLE;
          end else begin
            u_nxt     = u + IDX_W'(1);
            k_nxt     = '0;
            state_nxt = MAC;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else if (out_load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bus.mac_result;
      out_idx_q   <= u;
      out_last_q  <= (u == LAST_IDX);
    end else if (out_drop) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.mac_sample   = buf_rd;
  assign bus.mac_coef_row = u;
  assign bus.mac_coef_col = k;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_idx      = out_idx_q;
  assign bus.out_last     = out_last_q;

endmodule

// File: doc/dct_mac_sequencer.md
Name: dct_mac_sequencer

Overview:
- Control block for one DCT unit's shared multiply-accumulate datapath (macu) and its enable-gated result register.
- Accepts one 8-sample vector, then drives the MAC for 8 cycles per output coefficient u = 0..7.
- After the MAC pipeline drains, pulses the result-register enable and presents each coefficient on a valid/ready output stream.
- Sits between the row/column buffer and the zigzag stage inside fdct_zigzag.dct_mod.

Parameters:
- DATA_W, 8, width of one input sample (signed).
- ACC_W, 25, width of the MAC result and out_data (signed).
- N, 8, samples per vector and coefficients per vector; fixed at 8, other values unsupported.
- MAC_LAT, 1, MAC pipeline depth, 0..3; mac_result is valid MAC_LAT+1 cycles after the last mac_acc_en cycle.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  sequencer can accept a vector.
- in_data  in  N*DATA_W  samples; sample k is at bits [k*DATA_W +: DATA_W].
- mac_sample  out  DATA_W  multiplicand for the current MAC cycle.
- mac_coef_row  out  3  coefficient ROM row (u).
- mac_coef_col  out  3  coefficient ROM column (k).
- mac_acc_en  out  1  accumulate this cycle.
- mac_clr  out  1  with mac_acc_en: load the product instead of accumulating.
- mac_result  in  ACC_W  MAC accumulator output.
- result_en  out  1  one-cycle enable for macu.result capture.
- out_valid  out  1  coefficient valid.
- out_ready  in  1  downstream accepts.
- out_data  out  ACC_W  coefficient value (registered).
- out_idx  out  3  coefficient index u.
- out_last  out  1  high with out_valid when u = 7.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. Every flop, including the sample buffer, clears on rst.
- Reset values: in_ready = 1 (IDLE) and busy = 0. Every other output is 0, including out_valid, result_en, mac_acc_en, mac_clr, out_data, out_idx, out_last and all mac_* buses.
- States: IDLE, MAC, DRAIN, EMIT.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture in_data into the sample buffer, set u = 0, k = 0, go to MAC.
- MAC (exactly N cycles per coefficient):
  - mac_acc_en = 1, mac_sample = buf[k], mac_coef_row = u, mac_coef_col = k, mac_clr = (k == 0).
  - k increments each cycle. At k == 7, go to DRAIN with drain counter = MAC_LAT.
- DRAIN (MAC_LAT+1 cycles):
  - mac_acc_en = 0; mac_* buses hold their last values.
  - In the final DRAIN cycle: result_en = 1, out_data <= mac_result, out_idx <= u, out_last <= (u == 7), out_valid <= 1 next cycle, go to EMIT.
- EMIT:
  - Hold out_valid, out_data, out_idx and out_last stable until out_valid & out_ready.
  - On that handshake: out_valid falls next cycle. If u == 7, go to IDLE; else u++, k = 0, go to MAC.
- Timing with MAC_LAT = 1 and out_ready tied high:
  - Input handshake in cycle 0; MAC occupies cycles 1-8; DRAIN occupies 9-10.
  - out_valid is first high in cycle 11; coefficients are 11 cycles apart.
  - The final coefficient appears in cycle 88; in_ready is high again in cycle 89.
- Boundaries:
  - in_valid outside IDLE is ignored and not captured; in_ready = 0.
  - Backpressure stalls only in EMIT; no MAC activity occurs while stalled.
  - Because of mac_clr on k = 0, no accumulator state carries across coefficients or vectors.
  - A new vector cannot overlap the previous one; acceptance happens only in IDLE, the cycle after the u = 7 handshake.
  - rst mid-operation: return immediately to IDLE with reset values on all outputs. No partial output is emitted and no result_en pulse occurs.
  - u and k are 3-bit and wrap naturally; the state machine never relies on wrap.

Decomposition:
- Package dct_seq_pkg:
  - state enum (IDLE, MAC, DRAIN, EMIT);
  - N_PTS = 8;
  - IDX_W = 3;
  - MAC_LAT_MAX = 3.
- Sub-module dct_sample_buf: N x DATA_W register file with a load strobe and an indexed read. The FSM, counters and output register stay in dct_mac_sequencer.

Test Plan:
- Bench MAC model: coefficient = 1, accumulator = sum of samples.
  - Stimulus: samples all 1, MAC_LAT = 1, out_ready = 1.
  - Required: out_valid first in cycle 11, out_data = 8, out_idx = 0..7 at 11-cycle spacing, out_last only on idx 7, in_ready back in cycle 89.
- Samples 0..7 (signed), with a bench model using coefficient = col+1:
  - Required: each coefficient = sum of k*(k+1) = 168.
  - Required: mac_clr high exactly on the k = 0 cycle of every coefficient, so there is no carry-over.
- out_ready low for 5 cycles at idx 3:
  - Required: out_data and out_idx stable across the stall.
  - Required: mac_acc_en = 0 during the stall; MAC resumes the cycle after the handshake.
- in_valid held high throughout a vector:
  - Required: only one capture per vector; the second vector is captured in the first IDLE cycle after the idx 7 handshake.
- rst asserted during the DRAIN of idx 4:
  - Required: all outputs go to 0 asynchronously and in_ready = 1 after release.
  - Required: no result_en and no out_valid for idx 4.
- MAC_LAT = 0 and MAC_LAT = 3:
  - Required: first out_valid in cycle 10 and cycle 13 respectively.
  - Required: result_en is coincident with the cycle in which the model result is valid.
